nibble_accum: RTL and testbench

NIBBLE_ACCUM -- requirements
Module: nibble_accum

---
 rtl/nibble_accum_pkg.sv | 19 +
 rtl/nibble_accum_if.sv | 25 ++
 rtl/nibble_accum_mul10_add.sv | 18 +
 rtl/nibble_accum.sv | 92 +++++++++
 tb/tb_nibble_accum.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_accum_pkg.sv
// Shared types and constants for the decimal nibble accumulator.
// Build option: define NIBBLE_ACCUM_SAT_EN to clamp the value at 2^W-1 after overflow.
package nibble_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] NIBBLE_TERM = 4'hF;
   localparam int         DEC_BASE    = 10;

   // Any nibble that is not a decimal digit acts as a run terminator.
   function automatic logic is_digit(input logic [3:0] n);
      return n < 4'(DEC_BASE);
   endfunction

endpackage

// File: rtl/nibble_accum_if.sv
// Handshake bundle for nibble_accum: nibble input stream and run-result output.
// The master drives nibbles and out_ready; the slave returns the result.
interface nibble_accum_if #(
   parameter int W  = 16,
   parameter int CW = 5
);
   logic          in_valid;
   logic [3:0]    nibble;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  value;
   logic [CW-1:0] ndigits;
   logic          overflow;

   modport master (
      output in_valid, nibble, out_ready,
      input  in_ready, out_valid, value, ndigits, overflow
   );

   modport slave (
      input  in_valid, nibble, out_ready,
      output in_ready, out_valid, value, ndigits, overflow
   );
endinterface

// File: rtl/nibble_accum_mul10_add.sv
// Combinational acc*10+d evaluated at W+4 bits; any bit above W is reported as carry.
// 10*(2^W-1)+15 < 2^(W+4), so the wide sum itself never loses information.
module mul10_add
   import nibble_accum_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] acc,
   input  logic [3:0]   d,
   output logic [W-1:0] sum,
   output logic         carry
);
   logic [W+3:0] full;

   assign full  = (W+4)'(acc) * (W+4)'(DEC_BASE) + (W+4)'(d);
   assign sum   = full[W-1:0];
   assign carry = |full[W+3:W];
endmodule

// File: rtl/nibble_accum.sv
// Converts a stream of decimal digit nibbles into a binary value, one result per run.
// Build option: NIBBLE_ACCUM_SAT_EN clamps value at 2^W-1 after overflow instead of wrapping.
module nibble_accum
   import nibble_accum_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = 5
) (
   input  logic         clk,
   input  logic         rst,
   nibble_accum_if.slave bus
);
   state_t        state_reg, state_next;
   logic [W-1:0]  acc_reg, acc_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          ovf_reg, ovf_next;

   logic [W-1:0]  mac_sum;
   logic          mac_carry;
   logic          ovf_any;

   mul10_add #(.W(W)) u_mul10_add (
      .acc   (acc_reg),
      .d     (bus.nibble),
      .sum   (mac_sum),
      .carry (mac_carry)
   );

   assign ovf_any = ovf_reg | mac_carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            // Leading non-digits are swallowed without starting a run.
            if (bus.in_valid && is_digit(bus.nibble)) begin
               acc_next   = W'(bus.nibble);
               cnt_next   = CW'(1);
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               if (is_digit(bus.nibble)) begin
                  ovf_next = ovf_any;
`ifdef NIBBLE_ACCUM_SAT_EN
                  acc_next = ovf_any ? '1 : mac_sum;
`else
                  acc_next = mac_sum;
`endif
                  cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               acc_next   = '0;
               cnt_next   = '0;
               ovf_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // All outputs come straight from registers: no input-to-output path.
   assign bus.in_ready  = (state_reg != DONE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.value     = acc_reg;
   assign bus.ndigits   = cnt_reg;
   assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_nibble_accum.sv
// Self-checking bench for nibble_accum: directed scenarios plus a randomized stream
// scored against results computed from the digit string itself.
module tb_nibble_accum;
   import nibble_accum_pkg::*;

   localparam int W  = 16;
   localparam int CW = 5;
   localparam longint VMAX = (64'd1 << W) - 1;
   localparam int     NMAX = (1 << CW) - 1;

   typedef struct packed {
      logic [W-1:0]  v;
      logic [CW-1:0] n;
      logic          o;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   nibble_accum_if #(.W(W), .CW(CW)) bus ();

   nibble_accum #(.W(W), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Present one nibble until accepted, then drop in_valid; returns on a falling edge.
   task automatic drive(input logic [3:0] n);
      int w = 0;
      bus.in_valid = 1'b1;
      bus.nibble   = n;
      while (bus.in_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         checks++; errors++;
         $display("FAIL drive_timeout: in_ready=%b required 1 within 50 cycles", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.value !== '0 ||
          bus.ndigits !== '0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b val=%0d nd=%0d ovf=%b required 1 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.value, bus.ndigits, bus.overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      drive(4'd4);
      drive(4'd2);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early: out_valid=%b required 0", bus.out_valid);
      end
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.value !== 16'd42 ||
          bus.ndigits !== 5'd2 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_42: vld=%b rdy=%b val=%0d nd=%0d ovf=%b required 1 0 42 2 0",
                  bus.out_valid, bus.in_ready, bus.value, bus.ndigits, bus.overflow);
      end
      $display("basic result value=%0d ndigits=%0d overflow=%b", bus.value, bus.ndigits, bus.overflow);
      take_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.value !== '0) begin
         errors++;
         $display("FAIL basic_clear: vld=%b val=%0d required 0 0", bus.out_valid, bus.value);
      end
   endtask

   task automatic test_leading_term();
      drive(NIBBLE_TERM);
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL lead_term: out_valid=%b required 0", bus.out_valid);
      end
      drive(4'd7);
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.value !== 16'd7 || bus.ndigits !== 5'd1) begin
         errors++;
         $display("FAIL lead_7: vld=%b val=%0d nd=%0d required 1 7 1",
                  bus.out_valid, bus.value, bus.ndigits);
      end
      $display("lead result value=%0d ndigits=%0d", bus.value, bus.ndigits);
      take_result();
   endtask

   task automatic test_overflow();
      logic [W-1:0] want;
`ifdef NIBBLE_ACCUM_SAT_EN
      want = 16'hFFFF;
`else
      want = 16'd0;
`endif
      drive(4'd6); drive(4'd5); drive(4'd5); drive(4'd3); drive(4'd6);
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.value !== want || bus.ndigits !== 5'd5 ||
          bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_65536: vld=%b val=%0d nd=%0d ovf=%b required 1 %0d 5 1",
                  bus.out_valid, bus.value, bus.ndigits, bus.overflow, want);
      end
      $display("ovf result value=%0d ndigits=%0d overflow=%b", bus.value, bus.ndigits, bus.overflow);
      take_result();
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: overflow=%b required 0", bus.overflow);
      end
   endtask

   task automatic test_backpressure();
      drive(4'd8);
      drive(NIBBLE_TERM);
      bus.in_valid  = 1'b1;
      bus.nibble    = 4'd9;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.value !== 16'd8 ||
             bus.ndigits !== 5'd1) begin
            errors++;
            $display("FAIL stall_%0d: rdy=%b vld=%b val=%0d nd=%0d required 0 1 8 1",
                     i, bus.in_ready, bus.out_valid, bus.value, bus.ndigits);
         end
      end
      take_result();
      @(negedge clk);
      bus.in_valid = 1'b0;
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.value !== 16'd9 || bus.ndigits !== 5'd1) begin
         errors++;
         $display("FAIL stall_new_run: vld=%b val=%0d nd=%0d required 1 9 1",
                  bus.out_valid, bus.value, bus.ndigits);
      end
      $display("stall result value=%0d ndigits=%0d", bus.value, bus.ndigits);
      take_result();
   endtask

   task automatic test_async_reset();
      drive(4'd1);
      drive(4'd2);
      checks++;
      if (bus.ndigits !== 5'd2) begin
         errors++; $display("FAIL areset_pre: ndigits=%0d required 2", bus.ndigits);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.value !== '0 || bus.ndigits !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL areset_accum: val=%0d nd=%0d rdy=%b vld=%b required 0 0 1 0",
                  bus.value, bus.ndigits, bus.in_ready, bus.out_valid);
      end
      rst = 1'b0;
      @(negedge clk);
      drive(4'd3);
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.value !== 16'd3 || bus.ndigits !== 5'd1) begin
         errors++;
         $display("FAIL areset_3: vld=%b val=%0d nd=%0d required 1 3 1",
                  bus.out_valid, bus.value, bus.ndigits);
      end
      $display("areset result value=%0d ndigits=%0d", bus.value, bus.ndigits);
      // A pending result must vanish as soon as reset is applied.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.value !== '0) begin
         errors++;
         $display("FAIL areset_done: vld=%b rdy=%b val=%0d required 0 1 0",
                  bus.out_valid, bus.in_ready, bus.value);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      drive(4'd1);
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.value !== 16'd1 || bus.ndigits !== 5'd1) begin
         errors++;
         $display("FAIL b2b_first: vld=%b val=%0d nd=%0d required 1 1 1",
                  bus.out_valid, bus.value, bus.ndigits);
      end
      $display("b2b result value=%0d ndigits=%0d", bus.value, bus.ndigits);
      drive(4'd0);
      drive(NIBBLE_TERM);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.value !== 16'd0 || bus.ndigits !== 5'd1) begin
         errors++;
         $display("FAIL b2b_second: vld=%b val=%0d nd=%0d required 1 0 1",
                  bus.out_valid, bus.value, bus.ndigits);
      end
      $display("b2b result value=%0d ndigits=%0d", bus.value, bus.ndigits);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] stream[$];
      res_t       exp_q[$];
      res_t       r;
      longint     truev, wrapv;
      int         cnt, idx, got, cyc, len;
      bit         ovf, in_run;

      // Random runs: optional leading non-digits, a digit string, one terminator.
      for (int k = 0; k < 60; k++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            stream.push_back(4'($urandom_range(10, 15)));
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 40)) : int'($urandom_range(1, 7));
         for (int j = 0; j < len; j++)
            stream.push_back(($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 9)));
         stream.push_back(4'($urandom_range(10, 15)));
      end

      // Expected results straight from the decimal strings.
      in_run = 0; truev = 0; wrapv = 0; cnt = 0; ovf = 0;
      foreach (stream[i]) begin
         if (stream[i] <= 4'd9) begin
            if (!ovf) begin
               truev = truev * 10 + longint'(stream[i]);
               if (truev > VMAX) ovf = 1;
            end
            wrapv  = (wrapv * 10 + longint'(stream[i])) % (VMAX + 1);
            cnt++;
            in_run = 1;
         end else if (in_run) begin
`ifdef NIBBLE_ACCUM_SAT_EN
            r.v = ovf ? W'(VMAX) : W'(wrapv);
`else
            r.v = W'(wrapv);
`endif
            r.n = CW'((cnt > NMAX) ? NMAX : cnt);
            r.o = ovf;
            exp_q.push_back(r);
            in_run = 0; truev = 0; wrapv = 0; cnt = 0; ovf = 0;
         end
      end

      idx = 0; got = 0; cyc = 0;
      while ((idx < stream.size() || got < exp_q.size()) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         bus.in_valid  = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
         bus.nibble    = bus.in_valid ? stream[idx] : 4'($urandom_range(0, 15));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         checks++;
         if (bus.in_ready !== ~bus.out_valid) begin
            errors++;
            $display("FAIL rand_handshake: in_ready=%b out_valid=%b required opposite",
                     bus.in_ready, bus.out_valid);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            checks++;
            if (got >= exp_q.size()) begin
               errors++;
               $display("FAIL rand_extra: value=%0d required no result", bus.value);
            end else begin
               r = exp_q[got];
               if (bus.value !== r.v || bus.ndigits !== r.n || bus.overflow !== r.o) begin
                  errors++;
                  $display("FAIL rand_result_%0d: val=%0d nd=%0d ovf=%b required %0d %0d %b",
                           got, bus.value, bus.ndigits, bus.overflow, r.v, r.n, r.o);
               end
               $display("rand result %0d value=%0d ndigits=%0d overflow=%b",
                        got, bus.value, bus.ndigits, bus.overflow);
               got++;
            end
         end
         if (bus.in_valid && bus.in_ready === 1'b1) idx++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (got != exp_q.size() || idx != stream.size()) begin
         errors++;
         $display("FAIL rand_complete: results=%0d nibbles=%0d required %0d %0d",
                  got, idx, exp_q.size(), stream.size());
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.nibble    = 4'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_leading_term();
      test_overflow();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
